// File: rtl/sd_fifo_tx_filler.sv
// SD transmit-side filler: Wishbone read master that streams consecutive words into a FWFT FIFO.
// Optional bus-error handling is enabled by defining SD_TX_FILLER_ERR_EN.
module sd_fifo_tx_filler #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADR_STEP   = 4,
  parameter int OFFSET_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] m_wb_adr_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
`ifdef SD_TX_FILLER_ERR_EN
  input  logic        m_wb_err_i,
  output logic        err_o,
`endif
  input  logic        en,
  input  logic [31:0] adr,
  input  logic        rd,
  output logic [31:0] dat_o,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]         CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [OFFSET_W-1:0] STEP     = OFFSET_W'(ADR_STEP);

  typedef enum logic {IDLE, READ} state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] offset;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                bus_err;
  logic                halted;
  logic                push, pop;

`ifdef SD_TX_FILLER_ERR_EN
  assign bus_err = m_wb_err_i;
  assign halted  = err_o;
`else
  assign bus_err = 1'b0;
  assign halted  = 1'b0;
`endif

  // A word is accepted only on a clean ack of an active cycle; en=0 discards it.
  assign push  = (state_q == READ) && en && m_wb_ack_i && !bus_err;
  assign pop   = en && rd && !empty;
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en && !full && !halted) state_d = READ;
      READ: if (!en || bus_err || m_wb_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_wb_cyc_o = 1'b0;
    if (state_q == READ) m_wb_cyc_o = 1'b1;
  end

  assign m_wb_stb_o = m_wb_cyc_o;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_adr_o = adr + 32'(offset);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       offset <= '0;
    else if (!en)  offset <= '0;
    else if (push) offset <= offset + STEP;
  end

`ifdef SD_TX_FILLER_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_o <= 1'b0;
    else if (!en)                             err_o <= 1'b0;
    else if (state_q == READ && m_wb_err_i)   err_o <= 1'b1;
  end
`endif

  // NOTE: the storage array has no reset; dat_o is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= m_wb_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dat_o = empty ? '0 : mem[rd_ptr];

endmodule
